// File: rtl/selector_de_division_if.sv
// Button inputs and division-value outputs of selector_de_division.
interface selector_de_division_if #(
  parameter int WIDTH = 6
);
  logic             BTN_UP;
  logic             BTN_DOWN;
  logic [WIDTH-1:0] Q;
  logic             Cambio;
  logic             Limite;

  modport master (
    output BTN_UP, BTN_DOWN,
    input  Q, Cambio, Limite
  );

  modport slave (
    input  BTN_UP, BTN_DOWN,
    output Q, Cambio, Limite
  );
endinterface

// File: rtl/selector_de_division.sv
// Debounced up/down buttons step a saturating division value Q; optional auto-repeat under SELECTOR_AUTOREPEAT_EN.
// Q updates DEB_CYCLES+2 clocks after a clean press; no backpressure, one step per accepted press.
module selector_de_division #(
  parameter int WIDTH         = 6,
  parameter int DEB_CYCLES    = 16,
  parameter int Q_INIT        = 0,
  parameter int Q_MIN         = 0,
  parameter int Q_MAX         = 63,
  parameter int REPEAT_CYCLES = 1000
) (
  input logic                    CLK,
  input logic                    Reset,
  selector_de_division_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONF_PRESS, PRESSED, CONF_REL} deb_state_t;

  localparam int               CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] QINI     = WIDTH'(Q_INIT);
  localparam logic [WIDTH-1:0] QMIN     = WIDTH'(Q_MIN);
  localparam logic [WIDTH-1:0] QMAX     = WIDTH'(Q_MAX);
  localparam logic             LIM_INIT = (Q_INIT == Q_MIN) || (Q_INIT == Q_MAX);

  if (DEB_CYCLES < 2 || Q_MIN > Q_INIT || Q_INIT > Q_MAX ||
      Q_MAX >= (1 << WIDTH) || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("selector_de_division: invalid parameter set");
  end

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       raw, s1, s2;
  deb_state_t       st_q [2];
  deb_state_t       st_d [2];
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [1:0]       acc_d, acc_q;
  logic [WIDTH-1:0] q_r, q_n;
  logic             cambio_r, limite_r;

`ifdef SELECTOR_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
`endif

  assign raw = {bus.BTN_DOWN, bus.BTN_UP};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1    <= '0;
      s2    <= '0;
      acc_q <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
`ifdef SELECTOR_AUTOREPEAT_EN
        rcnt_q[i] <= '0;
`endif
      end
    end else begin
      s1    <= raw;
      s2    <= s1;
      acc_q <= acc_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef SELECTOR_AUTOREPEAT_EN
        rcnt_q[i] <= rcnt_d[i];
`endif
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        IDLE: begin
          if (s2[i]) begin
            st_d[i]  = CONF_PRESS;
            cnt_d[i] = CW'(1);
          end
        end
        CONF_PRESS: begin
          if (!s2[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]  = PRESSED;
            cnt_d[i] = '0;
            acc_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        PRESSED: begin
          if (!s2[i]) begin
            st_d[i]  = CONF_REL;
            cnt_d[i] = CW'(1);
          end
        end
        default: begin
          if (s2[i]) begin
            st_d[i]  = PRESSED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      endcase
`ifdef SELECTOR_AUTOREPEAT_EN
      // Repeat timer only advances while the button stays held; any exit clears it.
      rcnt_d[i] = '0;
      if (st_q[i] == PRESSED && st_d[i] == PRESSED) begin
        if (rcnt_q[i] == REP_LAST) begin
          acc_d[i] = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + RW'(1);
        end
      end
`endif
    end
  end

  // Bounds are checked before stepping so the arithmetic can never wrap.
  always_comb begin
    q_n = q_r;
    case (acc_q)
      2'b01:   if (q_r != QMAX) q_n = q_r + WIDTH'(1);
      2'b10:   if (q_r != QMIN) q_n = q_r - WIDTH'(1);
      default: q_n = q_r;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      q_r      <= QINI;
      cambio_r <= 1'b0;
      limite_r <= LIM_INIT;
    end else begin
      q_r      <= q_n;
      cambio_r <= (q_n != q_r);
      limite_r <= (q_n == QMIN) || (q_n == QMAX);
    end
  end

  assign bus.Q      = q_r;
  assign bus.Cambio = cambio_r;
  assign bus.Limite = limite_r;

endmodule

// File: doc/selector_de_division.md
Name: selector_de_division

Overview:
- Upstream stage of the frequency divider.
- Turns two raw push-button inputs (up/down) into the 6-bit division value Q the divider compares against.
- Each button is synchronised and debounced, then Q is incremented or decremented with saturation.
- Q is a registered, glitch-free output: it changes at most once per accepted press, so the divider never sees a transient value.

Parameters:
- WIDTH, 6: width of Q.
- DEB_CYCLES, 16: consecutive clocks a synchronised button level must hold to be accepted (>=2).
- Q_INIT, 0: value of Q after reset.
- Q_MIN, 0: lower saturation bound.
- Q_MAX, 63: upper saturation bound (Q_MIN <= Q_INIT <= Q_MAX).
- REPEAT_CYCLES, 1000: auto-repeat period in clocks. Used only with AUTOREPEAT_EN.

Ports:
- CLK  input  1  system clock, all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- BTN_UP  input  1  raw, asynchronous, bouncing "increase" button, active-high.
- BTN_DOWN  input  1  raw, asynchronous, bouncing "decrease" button, active-high.
- Q  output  WIDTH  current division value, registered; feeds the divider's Q input.
- Cambio  output  1  one-cycle pulse, high in the cycle after Q took a new value.
- Limite  output  1  registered; high while Q == Q_MIN or Q == Q_MAX.

Behaviour:
- Reset: one clock with Reset=1 sets:
  - Q = Q_INIT.
  - Cambio = 0.
  - Limite = (Q_INIT == Q_MIN || Q_INIT == Q_MAX).
  - Synchroniser flops = 0, both debounce FSMs = IDLE, all counters = 0.
  - Reset overrides any press in progress; a button still held after reset must pass the full debounce again.
- Synchroniser: each button passes through two flops; s = second flop output.
- Debounce FSM, one per button, with counter cnt (width clog2(DEB_CYCLES)+1):
  - IDLE: s=1 -> CONF_PRESS, cnt=1. Else stay.
  - CONF_PRESS: s=0 -> IDLE, cnt=0. s=1 and cnt==DEB_CYCLES-1 -> PRESSED, assert internal accept for one cycle. Else cnt+1.
  - PRESSED: s=0 -> CONF_REL, cnt=1. Else stay.
  - CONF_REL: s=1 -> PRESSED, cnt=0. s=0 and cnt==DEB_CYCLES-1 -> IDLE. Else cnt+1.
- Latency: take the first edge that samples raw BTN=1 as edge 0 (bouncing stops before it). The new Q is visible after edge DEB_CYCLES+2. Cambio is high during the following cycle.
- Update rules, evaluated on each accept:
  - up_acc only: Q = (Q == Q_MAX) ? Q : Q+1.
  - down_acc only: Q = (Q == Q_MIN) ? Q : Q-1.
  - up_acc and down_acc in the same cycle: Q unchanged, no Cambio.
- Saturation: no wrap-around. At Q_MAX an up press leaves Q unchanged, Cambio stays 0, Limite stays 1. Same for down at Q_MIN.
- Cambio: 1 only if Q actually changed on that edge.
- Limite: recomputed from the next value of Q, so it is aligned with Q.
- One accept per press: holding a button produces no further changes (unless AUTOREPEAT_EN).
- Glitch rejection: any high pulse on s shorter than DEB_CYCLES cycles produces no change.
- Arithmetic: WIDTH-bit unsigned. Compare against the bounds before adding, so no overflow is possible.

Optional Feature:
- Macro: SELECTOR_AUTOREPEAT_EN.
- Defined:
  - A per-button repeat counter runs while its FSM is in PRESSED and clears on leaving PRESSED.
  - Every REPEAT_CYCLES clocks spent in PRESSED produces an additional accept pulse.
  - First repeat fires REPEAT_CYCLES cycles after the initial accept.
  - Saturation and simultaneous-press rules apply unchanged.
- Undefined: no repeat logic is synthesised; REPEAT_CYCLES is ignored and a held button yields exactly one step.

Test Plan:
1. DEB_CYCLES=4, Q_INIT=10. Reset 1 cycle, then hold BTN_UP clean for 20 cycles -> Q=11 after edge 6, Cambio high exactly 1 cycle, Q stays 11 while held.
2. DEB_CYCLES=4, Q=11. Bounce BTN_DOWN 1,0,1,0 on successive edges, then hold 1 for 10 cycles -> exactly one decrement, Q=10. Glitches of 3 cycles alone -> Q unchanged, Cambio never 1.
3. Q_MAX=63, Q=62. Two separate clean up presses -> first gives Q=63, Cambio=1, Limite=1; second leaves Q=63, Cambio=0, Limite=1. Mirror at Q_MIN=0: Q=1 with two down presses -> Q=0, then stays 0.
4. BTN_UP and BTN_DOWN rise on the same edge and are held -> both FSMs reach PRESSED on the same edge, Q unchanged, Cambio=0.
5. Assert Reset while an up press is in CONF_PRESS (cnt=2), keep BTN_UP high -> after reset Q=Q_INIT; the next increment appears DEB_CYCLES+2 edges after Reset deasserts, not earlier.
6. With SELECTOR_AUTOREPEAT_EN, REPEAT_CYCLES=8, Q=0: hold BTN_UP for 40 cycles after accept -> Q=5 (1 initial + 4 repeats at 8, 16, 24, 32). Without the macro, the same stimulus gives Q=1.
